result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, result word width in bits.
REQ-002 SHALL have parameter DEPTH, default 14, words per frame; legal range 2..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current frame.
REQ-006 SHALL have port wr_valid  input  1  producer offers wr_data.
REQ-007 SHALL have port wr_data  input  DATA_W  result word from the compute stage.
REQ-008 SHALL have port wr_ready  output  1  buffer accepts a word this cycle.
REQ-009 SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-010 SHALL have port rd_data  output  DATA_W  word at rd_addr.
REQ-011 SHALL have port rd_ready  input  1  consumer takes rd_data this cycle.
REQ-012 SHALL have port wr_addr  output  4  next write slot.
REQ-013 SHALL have port rd_addr  output  4  next read slot.
REQ-014 SHALL have port count  output  4  words currently stored.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last word of a frame is read.

Function
REQ-016 SHALL implement a two-state FSM with states FILL and DRAIN, and storage of DEPTH x DATA_W registers.
REQ-017 In FILL: wr_ready=1 and rd_valid=0.
REQ-018 In DRAIN: wr_ready=0 and rd_valid=1.
REQ-019 A write occurs when wr_valid && wr_ready: mem[wr_addr] <= wr_data, count +1.
REQ-020 On a write, wr_addr SHALL increment, wrapping DEPTH-1 -> 0.
REQ-021 The write that makes count==DEPTH SHALL move the FSM to DRAIN on the same edge.
REQ-022 rd_data SHALL equal mem[rd_addr] combinationally whenever rd_valid=1; its value is don't-care in FILL.
REQ-023 A read occurs when rd_valid && rd_ready: count -1, rd_addr increments, wrapping DEPTH-1 -> 0.
REQ-024 The read that makes count==0 SHALL move the FSM to FILL and assert frame_done for exactly the next cycle.
REQ-025 Zero-latency handshakes: words may transfer on consecutive cycles, so a frame drains in DEPTH cycles with rd_ready held high.
REQ-026 wr_valid in DRAIN and rd_ready in FILL SHALL be ignored; no storage, pointer or count change.
REQ-027 Reads and writes never coincide because of the state split; count never exceeds DEPTH or goes below 0.
REQ-028 When flush=1, on the next edge: FSM=FILL, wr_addr=rd_addr=count=0, frame_done=0; storage contents unchanged.
REQ-029 flush SHALL override any write or read handshake in that cycle, and no frame_done SHALL be produced for the aborted frame.
REQ-030 frame_done SHALL be registered and SHALL never be high for two consecutive cycles.

Reset
REQ-031 reset=0 at a clk edge SHALL force: FSM=FILL, wr_addr=0, rd_addr=0, count=0, frame_done=0.
REQ-032 After that reset edge, the outputs SHALL read wr_ready=1, rd_valid=0.
REQ-033 reset SHALL take priority over flush and over all handshakes.
REQ-034 Reset asserted mid-frame SHALL discard the frame's progress; storage contents need not be cleared.
REQ-035 Outputs SHALL not change asynchronously on reset assertion.

Verification
REQ-036 Scenario: after reset, write words 0x0001..0x000E on 14 consecutive cycles, then hold rd_ready=1. Required: wr_ready drops after the 14th write; rd_data reads 0x0001..0x000E on 14 consecutive cycles; frame_done pulses once; wr_ready=1 again.
REQ-037 Scenario: drive wr_valid during DRAIN with data 0xBEEF. Required: no storage change, count stays, drained data matches the original frame.
REQ-038 Scenario: rd_ready toggles 1,0,1,0 during DRAIN. Required: rd_addr advances only on rd_ready=1 cycles; rd_data is stable while rd_ready=0.
REQ-039 Scenario: flush after 7 writes. Required: count=0, wr_addr=0, FILL state, no frame_done; the next 14 writes form a complete frame.
REQ-040 Scenario: reset=0 asserted at rd_addr=9 in DRAIN. Required: next cycle FILL, all pointers and count at 0, no frame_done.
REQ-041 Scenario: run two back-to-back frames. Required: wr_addr and rd_addr wrap 13 -> 0; frame_done pulses exactly twice.

Source files
------------

// File: rtl/result_buffer.sv
// Frame-based result buffer: collects DEPTH words from the compute stage, then
// drains them in order to the consumer before accepting the next frame.
module result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [3:0]        wr_addr,
  output logic [3:0]        rd_addr,
  output logic [3:0]        count,
  output logic              frame_done
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ADDR  = 4'(DEPTH - 1);
  localparam logic [3:0] FULL_LESS1 = 4'(DEPTH - 1);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        wr_addr_r;
  logic [3:0]        rd_addr_r;
  logic [3:0]        count_r;
  logic              frame_done_r;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              last_rd_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state, handshake qualification and state-decoded flow control
  always_comb begin
    state_s   = state_r;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    last_rd_s = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    case (state_r)
      FILL: begin
        wr_ready = 1'b1;
        wr_en_s  = wr_valid;
        if (wr_valid && (count_r == FULL_LESS1)) begin
          state_s = DRAIN;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        rd_valid  = 1'b1;
        rd_en_s   = rd_ready;
        last_rd_s = rd_ready && (count_r == 4'd1);
        if (last_rd_s) begin
          state_s = FILL;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // Control registers; reset beats flush, flush beats any handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= FILL;
      wr_addr_r    <= 4'd0;
      rd_addr_r    <= 4'd0;
      count_r      <= 4'd0;
      frame_done_r <= 1'b0;
    end else if (flush) begin
      state_r      <= FILL;
      wr_addr_r    <= 4'd0;
      rd_addr_r    <= 4'd0;
      count_r      <= 4'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_done_r <= last_rd_s;
      if (wr_en_s) begin
        wr_addr_r <= (wr_addr_r == LAST_ADDR) ? 4'd0 : wr_addr_r + 4'd1;
        count_r   <= count_r + 4'd1;
      end else if (rd_en_s) begin
        rd_addr_r <= (rd_addr_r == LAST_ADDR) ? 4'd0 : rd_addr_r + 4'd1;
        count_r   <= count_r - 4'd1;
      end else begin
        count_r   <= count_r;
      end
    end
  end

  // Storage is never cleared; only an accepted, non-aborted write touches it
  always_ff @(posedge clk) begin
    if (reset && !flush && wr_en_s) begin
      mem_r[wr_addr_r] <= wr_data;
    end
  end

  assign rd_data    = mem_r[rd_addr_r];
  assign wr_addr    = wr_addr_r;
  assign rd_addr    = rd_addr_r;
  assign count      = count_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed scenarios plus a random phase,
// compared against a queue-based frame model.
module tb_result_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 14;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic [3:0]        wr_addr;
  logic [3:0]        rd_addr;
  logic [3:0]        count;
  logic              frame_done;

  result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .count(count),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;
  int fd_model = 0;

  // Reference model: the frame as a queue plus a draining flag
  logic [DATA_W-1:0] frame_q [$];
  bit m_drain = 1'b0;
  int m_wa = 0;
  int m_ra = 0;
  bit m_fd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    if (frame_done === 1'b1) fd_seen++;
    chk("wr_ready", 32'(wr_ready), 32'(!m_drain));
    chk("rd_valid", 32'(rd_valid), 32'(m_drain));
    chk("count", 32'(count), 32'(frame_q.size()));
    chk("wr_addr", 32'(wr_addr), 32'(m_wa));
    chk("rd_addr", 32'(rd_addr), 32'(m_ra));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_drain) chk("rd_data", 32'(rd_data), 32'(frame_q[0]));
  endtask

  task automatic model_clear();
    frame_q.delete();
    m_drain = 1'b0;
    m_wa = 0;
    m_ra = 0;
    m_fd = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit fl, input bit wv,
                            input logic [DATA_W-1:0] wd, input bit rr);
    bit nfd;
    nfd = 1'b0;
    if (!rst || fl) begin
      model_clear();
    end else begin
      if (!m_drain && wv) begin
        frame_q.push_back(wd);
        m_wa = (m_wa + 1) % DEPTH;
        if (frame_q.size() == DEPTH) m_drain = 1'b1;
      end else if (m_drain && rr) begin
        void'(frame_q.pop_front());
        m_ra = (m_ra + 1) % DEPTH;
        if (frame_q.size() == 0) begin
          m_drain = 1'b0;
          nfd = 1'b1;
          fd_model++;
        end
      end
      m_fd = nfd;
    end
  endtask

  task automatic cyc(input bit rst, input bit fl, input bit wv,
                     input logic [DATA_W-1:0] wd, input bit rr);
    reset = rst; flush = fl; wr_valid = wv; wr_data = wd; rd_ready = rr;
    @(negedge clk);
    check_outputs();
    model_step(rst, fl, wv, wd, rr);
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame_random(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, DATA_W'($urandom), 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Sequential frame 0x0001..0x000E, then drain with rd_ready held
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, DATA_W'(i), 1'b0);
    chk("full_wr_ready_low", 32'(wr_ready), 32'd0);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("frame1_pulses", 32'(fd_seen), 32'd1);

    // Writes offered during DRAIN are ignored
    write_frame_random(DEPTH);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    // The final cycle above refilled one 0xBEEF word in FILL; flush it away
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

    // rd_ready toggling during DRAIN
    write_frame_random(DEPTH);
    for (int i = 0; i < 2 * DEPTH + 2; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'((i + 1) % 2));

    // Flush after 7 writes, then a full frame
    write_frame_random(7);
    cyc(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
    write_frame_random(DEPTH);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset in DRAIN at rd_addr 9
    write_frame_random(DEPTH);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("rd_addr_before_reset", 32'(rd_addr), 32'd9);
    cyc(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Two back-to-back frames, pointers wrap 13 -> 0
    fd_seen = 0;
    fd_model = 0;
    for (int f = 0; f < 2; f++) begin
      write_frame_random(DEPTH);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("b2b_pulses", 32'(fd_seen), 32'd2);

    // Random traffic with occasional flush and reset
    fd_seen = 0;
    fd_model = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("random_pulses", 32'(fd_seen), 32'(fd_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
